// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, sequencer state encoding and small classification helpers.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // Counter width is generous so any legal latency parameter fits.
  localparam int CNT_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Result waiting for the end of the busy sequence; we=0 marks divide-by-zero.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
  } md_result_t;

  function automatic logic is_mult(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul_div(input md_op_e op);
    return is_mult(op) || is_div(op);
  endfunction

endpackage

// File: rtl/md_if.sv
// E-stage request/response bundle between the decoder/forwarding logic and
// the multiply/divide unit.
interface md_if import md_pkg::*; ();

  logic        start;
  md_op_e      md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_seq.sv
// IDLE/RUN sequencer: holds busy for exactly `cycles` cycles after a load and
// raises done in the last busy cycle so the write-back lands on the falling edge.
module md_seq import md_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state <= ST_RUN;
            cnt   <= cycles - CNT_W'(1);
            busy  <= 1'b1;
            done  <= (cycles == CNT_W'(1));
          end
        end
        ST_RUN: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit: computes the result on the accepting edge,
// holds it pending for a fixed busy window, then commits it to HI/LO.
module md_unit import md_pkg::*; #(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  logic             busy;
  logic             done;
  logic             accept_md;
  logic             accept_mt;
  logic [CNT_W-1:0] cycles;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  md_result_t next_res;
  md_result_t pend;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // busy is registered, so a start during the busy window can never be accepted.
  assign accept_md = bus.start && !busy && is_mul_div(bus.md_op);
  assign accept_mt = bus.start && !busy &&
                     ((bus.md_op == MD_MTHI) || (bus.md_op == MD_MTLO));
  assign cycles    = is_mult(bus.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  md_seq u_seq (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_md),
    .cycles (cycles),
    .busy   (busy),
    .done   (done)
  );

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{bus.src_a[31]}}, bus.src_a} * {{32{bus.src_b[31]}}, bus.src_b};
  assign prod_u = {32'b0, bus.src_a} * {32'b0, bus.src_b};

  // Signed divide on magnitudes avoids the -2^31 / -1 overflow trap entirely.
  assign signed_div = (bus.md_op == MD_DIV);
  assign a_mag  = (signed_div && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign b_mag  = (signed_div && bus.src_b[31]) ? -bus.src_b : bus.src_b;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (signed_div && (bus.src_a[31] ^ bus.src_b[31])) ? -q_mag : q_mag;
  assign rem    = (signed_div && bus.src_a[31]) ? -r_mag : r_mag;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    next_res = '0;
    case (bus.md_op)
      MD_MULT: begin
        next_res.hi = prod_s[63:32];
        next_res.lo = prod_s[31:0];
        next_res.we = 1'b1;
      end
      MD_MULTU: begin
        next_res.hi = prod_u[63:32];
        next_res.lo = prod_u[31:0];
        next_res.we = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        next_res.hi = rem;
        next_res.lo = quot;
        next_res.we = (bus.src_b != 32'd0);
      end
      default: next_res = '0;
    endcase
  end

  // NOTE: the pending result is reset too, so an aborted operation can never write back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept_md) begin
        pend <= next_res;
      end
      if (done) begin
        if (pend.we) begin
          hi_q <= pend.hi;
          lo_q <= pend.lo;
        end
      end else if (accept_mt) begin
        if (bus.md_op == MD_MTHI) begin
          hi_q <= bus.src_a;
        end else begin
          lo_q <= bus.src_a;
        end
      end
    end
  end

  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: the driver schedules expected HI/LO/busy snapshots
// per cycle and expected busy-run lengths; independent monitors compare them.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  md_if bus();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned len_q[$];
  int unsigned cyc = 0;
  int unsigned run = 0;
  int          ign = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_at(input int unsigned at, input logic b, input logic [31:0] h,
                           input logic [31:0] l, input string name);
    exp_t e;
    e.at = at; e.busy = b; e.hi = h; e.lo = l; e.name = name;
    exp_q.push_back(e);
  endtask

  // Called at a negedge: request held for exactly one accepting edge.
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_a = $urandom();
    bus.src_b = $urandom();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({name, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset === 1'b1 && bus.start === 1'b1 && bus.busy === 1'b1) ign <= ign + 1;
  end

  // Scoreboard monitor: snapshot checks by cycle, busy-run lengths on each fall.
  always @(negedge clk) begin
    for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        check({exp_q[i].name, "_busy"}, 32'(bus.busy), 32'(exp_q[i].busy));
        check({exp_q[i].name, "_hi"}, bus.hi, exp_q[i].hi);
        check({exp_q[i].name, "_lo"}, bus.lo, exp_q[i].lo);
        exp_q.delete(i);
      end
    end
    if (bus.busy === 1'b1) begin
      run++;
    end else if (run != 0) begin
      if (len_q.size() == 0) check("busy_run_unexpected", 32'(run), 32'd0);
      else check("busy_run_len", 32'(run), 32'(len_q.pop_front()));
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t;

    // Reset held with a live mthi request: nothing may be captured.
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.md_op = MD_MTHI;
    bus.src_a = 32'hDEADBEEF;
    bus.src_b = 32'h0;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, 1'b0, 32'h0, 32'h0, "reset_with_start");
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    expect_at(cyc + 1, 1'b0, 32'h0, 32'h0, "post_reset_idle");
    @(negedge clk);

    // mult -2 * 3
    t = cyc;
    expect_at(t + 1, 1'b1, 32'h0, 32'h0, "mult_busy_first");
    expect_at(t + 5, 1'b1, 32'h0, 32'h0, "mult_busy_last");
    expect_at(t + 6, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_result");
    len_q.push_back(5);
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult");

    // multu max * max, HI/LO held while busy
    @(negedge clk);
    t = cyc;
    expect_at(t + 1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, "multu_hold_first");
    expect_at(t + 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, "multu_hold_last");
    expect_at(t + 6, 1'b0, 32'hFFFFFFFE, 32'h00000001, "multu_result");
    len_q.push_back(5);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu");

    // div -7 / 2 with a stray mtlo injected while busy
    @(negedge clk);
    t = cyc;
    expect_at(t + 2, 1'b1, 32'hFFFFFFFE, 32'h00000001, "div_ignore_mtlo");
    expect_at(t + 10, 1'b1, 32'hFFFFFFFE, 32'h00000001, "div_busy_last");
    expect_at(t + 11, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_result");
    len_q.push_back(10);
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    bus.start = 1'b1;
    bus.md_op = MD_MTLO;
    bus.src_a = 32'h55555555;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("div");

    // divu 7 / 0 keeps HI/LO but runs the full sequence
    @(negedge clk);
    t = cyc;
    expect_at(t + 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, "divu0_busy_last");
    expect_at(t + 11, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, "divu0_keep");
    len_q.push_back(10);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle("divu0");

    // div 7 / -2: quotient toward zero, remainder takes dividend sign
    @(negedge clk);
    t = cyc;
    expect_at(t + 11, 1'b0, 32'h00000001, 32'hFFFFFFFD, "div_pos_neg");
    len_q.push_back(10);
    issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle("div_pos_neg");

    // div overflow corner
    @(negedge clk);
    t = cyc;
    expect_at(t + 11, 1'b0, 32'h00000000, 32'h80000000, "div_ovf");
    len_q.push_back(10);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    // mthi then mtlo on consecutive edges, no busy
    @(negedge clk);
    t = cyc;
    expect_at(t + 1, 1'b0, 32'h12345678, 32'h80000000, "mthi");
    expect_at(t + 2, 1'b0, 32'h12345678, 32'h9ABCDEF0, "mtlo");
    issue(MD_MTHI, 32'h12345678, 32'h0);
    issue(MD_MTLO, 32'h9ABCDEF0, 32'h0);

    // Undefined op code is a no-op
    t = cyc;
    expect_at(t + 1, 1'b0, 32'h12345678, 32'h9ABCDEF0, "op7_noop");
    issue(md_op_e'(3'd7), 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Reset during the third busy cycle of a div
    @(negedge clk);
    t = cyc;
    expect_at(t + 3, 1'b1, 32'h12345678, 32'h9ABCDEF0, "div_pre_reset");
    expect_at(t + 4, 1'b0, 32'h0, 32'h0, "reset_mid_div");
    expect_at(t + 11, 1'b0, 32'h0, 32'h0, "no_late_wb_a");
    expect_at(t + 12, 1'b0, 32'h0, 32'h0, "no_late_wb_b");
    len_q.push_back(3);
    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(negedge clk);

    // Back-to-back mult: second accepted in the cycle busy first reads 0
    t = cyc;
    expect_at(t + 6, 1'b0, 32'h0, 32'h0000002A, "b2b_first");
    expect_at(t + 7, 1'b1, 32'h0, 32'h0000002A, "b2b_second_busy");
    expect_at(t + 11, 1'b1, 32'h0, 32'h0000002A, "b2b_second_hold");
    expect_at(t + 12, 1'b0, 32'h1, 32'h0, "b2b_second_result");
    len_q.push_back(5);
    len_q.push_back(5);
    issue(MD_MULT, 32'd6, 32'd7);
    wait_idle("b2b_first");
    check("b2b_accept_cycle", cyc, t + 6);
    issue(MD_MULT, 32'h00010000, 32'h00010000);
    wait_idle("b2b_second");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("busy_runs_drained", 32'(len_q.size()), 32'd0);
    check("ignored_starts", 32'(ign), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
